int_service_agent: RTL

//  Service-side partner of the priority interrupt controller.
//  - Collects per-peripheral event pulses into a pending register and presents it as int_active_o.
//  - Accepts the controller's int_valid/int_to_service request and models a service routine of fixed length.
//  - Returns int_serviced_o with a 4-phase level handshake and clears the serviced pending bit.
//  - Used as the CPU/ISR model in subsystem benches and as the service sequencer in FPGA builds.

---
 rtl/int_service_agent.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/int_service_agent.sv
// int_service_agent: service-side partner of the priority interrupt controller.
// Collects event pulses into a pending register, accepts one request at a time,
// models a fixed-length service routine and answers with a 4-phase level handshake.
module int_service_agent #(
    parameter int NUM_PERIPHS   = 16,
    parameter int PERIPHS_INDEX = $clog2(NUM_PERIPHS),
    parameter int SVC_CYCLES    = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     pclk_i,
    input  logic                     prst_i,
    input  logic [NUM_PERIPHS-1:0]   irq_pulse_i,
    output logic [NUM_PERIPHS-1:0]   int_active_o,
    input  logic                     int_valid_i,
    input  logic [PERIPHS_INDEX-1:0] int_to_service_i,
    input  logic                     hold_i,
    output logic                     int_serviced_o,
    output logic                     svc_busy_o,
    output logic [PERIPHS_INDEX-1:0] svc_id_o,
    output logic [CNT_WIDTH-1:0]     svc_count_o,
    output logic [CNT_WIDTH-1:0]     ovf_count_o,
    output logic                     err_o
);

    // Service counter width; a single-cycle service still needs one bit.
    localparam int SC_W  = (SVC_CYCLES > 1) ? $clog2(SVC_CYCLES) : 1;
    // Width able to hold the number of overflow events on a single edge.
    localparam int PC_W  = $clog2(NUM_PERIPHS + 1);
    // Wide enough that counter + per-edge increment never wraps before saturation.
    localparam int SUM_W = CNT_WIDTH + PC_W;

    localparam logic [SC_W-1:0]  SVC_LAST = SC_W'(SVC_CYCLES - 1);
    localparam logic [SUM_W-1:0] CNT_MAX  = SUM_W'({CNT_WIDTH{1'b1}});

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_SERVICE = 3'b010,
        ST_DONE    = 3'b100
    } state_t;

    state_t                   state_reg,     state_next;
    logic [SC_W-1:0]          cnt_reg,       cnt_next;
    logic [PERIPHS_INDEX-1:0] svc_id_reg,    svc_id_next;
    logic                     serviced_reg,  serviced_next;
    logic                     err_reg,       err_next;
    logic [CNT_WIDTH-1:0]     svc_count_reg, svc_count_next;
    logic [CNT_WIDTH-1:0]     ovf_count_reg, ovf_count_next;
    logic [NUM_PERIPHS-1:0]   pend_reg,      pend_next;

    logic                     clr_en;
    logic [NUM_PERIPHS-1:0]   clr_vec;
    logic [NUM_PERIPHS-1:0]   ovf_vec;
    logic [PC_W-1:0]          ovf_pop;
    logic [SUM_W-1:0]         ovf_sum;

    // Per-source clear decode and lost-event detection. A bit being cleared on
    // this edge is not an overflow: the new pulse simply re-pends it.
    generate
        for (genvar gi = 0; gi < NUM_PERIPHS; gi++) begin : g_src
            assign clr_vec[gi] = clr_en && (svc_id_reg == PERIPHS_INDEX'(gi));
            assign ovf_vec[gi] = irq_pulse_i[gi] & pend_reg[gi] & ~clr_vec[gi];
        end
    endgenerate

    // Pending update: set wins over clear on the same bit.
    assign pend_next = (pend_reg & ~clr_vec) | irq_pulse_i;

    // Count lost events this edge and add them to the saturating overflow counter.
    always_comb begin
        ovf_pop = '0;
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            ovf_pop = ovf_pop + PC_W'(ovf_vec[i]);
        end
        ovf_sum        = SUM_W'(ovf_count_reg) + SUM_W'(ovf_pop);
        ovf_count_next = (ovf_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : ovf_sum[CNT_WIDTH-1:0];
    end

    // Service sequencer: next state, counter, handshake and statistics.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        svc_id_next    = svc_id_reg;
        serviced_next  = serviced_reg;
        err_next       = err_reg;
        svc_count_next = svc_count_reg;
        clr_en         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (int_valid_i) begin
                    svc_id_next = int_to_service_i;
                    if (pend_reg[int_to_service_i]) begin
                        cnt_next   = '0;
                        state_next = ST_SERVICE;
                    end else begin
                        // Spurious request: answer at once so the controller never stalls.
                        err_next      = 1'b1;
                        serviced_next = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
            end
            ST_SERVICE: begin
                if (!int_valid_i) begin
                    // Request withdrawn: abandon quietly.
                    state_next = ST_IDLE;
                end else if (!hold_i) begin
                    if (cnt_reg == SVC_LAST) begin
                        state_next    = ST_DONE;
                        serviced_next = 1'b1;
                        clr_en        = 1'b1;
                        if (svc_count_reg != {CNT_WIDTH{1'b1}}) begin
                            svc_count_next = svc_count_reg + CNT_WIDTH'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + SC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!int_valid_i) begin
                    serviced_next = 1'b0;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                serviced_next = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            svc_id_reg    <= '0;
            serviced_reg  <= 1'b0;
            err_reg       <= 1'b0;
            svc_count_reg <= '0;
            ovf_count_reg <= '0;
            pend_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            svc_id_reg    <= svc_id_next;
            serviced_reg  <= serviced_next;
            err_reg       <= err_next;
            svc_count_reg <= svc_count_next;
            ovf_count_reg <= ovf_count_next;
            pend_reg      <= pend_next;
        end
    end

    assign int_active_o   = pend_reg;
    assign int_serviced_o = serviced_reg;
    assign svc_busy_o     = (state_reg == ST_SERVICE) || (state_reg == ST_DONE);
    assign svc_id_o       = svc_id_reg;
    assign svc_count_o    = svc_count_reg;
    assign ovf_count_o    = ovf_count_reg;
    assign err_o          = err_reg;

endmodule
